// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_e;

    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

    function automatic logic is_div_op(input muldiv_op_e op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

    function automatic logic is_rem_op(input muldiv_op_e op);
        return (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/muldiv_decode.sv
// Combinational M-extension decode: selects the unit, names the op and
// reports operand signedness and whether the high product half is returned.
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic       m_sel,
    output muldiv_op_e op,
    output logic       a_signed,
    output logic       b_signed,
    output logic       hi_sel
);

    always_comb begin
        m_sel    = (alu_op == ALUOP_RTYPE) && (funct7 == FUNCT7_MEXT);
        op       = muldiv_op_e'(funct3);
        a_signed = 1'b0;
        b_signed = 1'b0;
        hi_sel   = 1'b0;
        case (op)
            MUL:    begin a_signed = 1'b1; b_signed = 1'b1; end
            MULH:   begin a_signed = 1'b1; b_signed = 1'b1; hi_sel = 1'b1; end
            MULHSU: begin a_signed = 1'b1; hi_sel = 1'b1; end
            MULHU:  hi_sel = 1'b1;
            DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
            REM:    begin a_signed = 1'b1; b_signed = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response.
// Define MULDIV_DIV_EN to build the divider; otherwise divide ops return 0 in one cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [1:0]            alu_op,
    input  logic [6:0]            funct7,
    input  logic [2:0]            funct3,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  m_sel,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result
);

    localparam int DW = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    muldiv_state_e state, state_nxt;
    muldiv_op_e    dec_op;
    logic          dec_a_signed, dec_b_signed, dec_hi_sel;

    logic [2*DW-1:0] prod, step_val, prod_fix;
    logic [DW-1:0]   mcand, mag_a, mag_b, final_val, special_val, result_q;
    logic [DW:0]     mul_sum;
    logic [CNT_W-1:0] cnt;
    logic            a_neg, b_neg, accept, special, neg_res, hi_q;

    muldiv_decode u_decode (
        .alu_op   (alu_op),
        .funct7   (funct7),
        .funct3   (funct3),
        .m_sel    (m_sel),
        .op       (dec_op),
        .a_signed (dec_a_signed),
        .b_signed (dec_b_signed),
        .hi_sel   (dec_hi_sel)
    );

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign accept    = in_valid && in_ready && m_sel;

    assign a_neg = dec_a_signed & op_a[DW-1];
    assign b_neg = dec_b_signed & op_b[DW-1];
    assign mag_a = a_neg ? -op_a : op_a;
    assign mag_b = b_neg ? -op_b : op_b;

`ifdef MULDIV_DIV_EN
    localparam logic [DW-1:0] MIN_VAL = {1'b1, {(DW-1){1'b0}}};

    logic [DW:0]   div_shift, div_diff;
    logic [DW-1:0] quo, rem;
    logic          div_q, rem_q, neg_rem;

    // Divide by zero and MIN/-1 never enter CALC; their results are fixed.
    always_comb begin
        special     = 1'b0;
        special_val = '0;
        if (is_div_op(dec_op)) begin
            if (op_b == '0) begin
                special     = 1'b1;
                special_val = is_rem_op(dec_op) ? op_a : '1;
            end else if ((dec_op == DIV || dec_op == REM) && op_a == MIN_VAL && op_b == '1) begin
                special     = 1'b1;
                special_val = is_rem_op(dec_op) ? '0 : MIN_VAL;
            end
        end
    end
`else
    always_comb begin
        special     = is_div_op(dec_op);
        special_val = '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (cnt == CNT_LAST) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    // prod holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum  = {1'b0, prod[2*DW-1:DW]} + (prod[0] ? {1'b0, mcand} : '0);
        step_val = {mul_sum, prod[DW-1:1]};
`ifdef MULDIV_DIV_EN
        div_shift = {prod[2*DW-1:DW], prod[DW-1]};
        div_diff  = div_shift - {1'b0, mcand};
        if (div_q) begin
            step_val = div_diff[DW] ? {div_shift[DW-1:0], prod[DW-2:0], 1'b0}
                                    : {div_diff[DW-1:0], prod[DW-2:0], 1'b1};
        end
`endif
    end

    // The final iteration's output is sign-corrected in the same step.
    always_comb begin
        prod_fix  = neg_res ? -step_val : step_val;
        final_val = hi_q ? prod_fix[2*DW-1:DW] : prod_fix[DW-1:0];
`ifdef MULDIV_DIV_EN
        quo = step_val[DW-1:0];
        rem = step_val[2*DW-1:DW];
        if (div_q) final_val = rem_q ? (neg_rem ? -rem : rem) : (neg_res ? -quo : quo);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod     <= '0;
            mcand    <= '0;
            cnt      <= '0;
            neg_res  <= 1'b0;
            hi_q     <= 1'b0;
            result_q <= '0;
`ifdef MULDIV_DIV_EN
            div_q    <= 1'b0;
            rem_q    <= 1'b0;
            neg_rem  <= 1'b0;
`endif
        end else if (!flush) begin
            case (state)
                IDLE: if (accept) begin
                    prod    <= {{DW{1'b0}}, mag_a};
                    mcand   <= mag_b;
                    cnt     <= '0;
                    neg_res <= a_neg ^ b_neg;
                    hi_q    <= dec_hi_sel;
`ifdef MULDIV_DIV_EN
                    div_q   <= is_div_op(dec_op);
                    rem_q   <= is_rem_op(dec_op);
                    neg_rem <= a_neg;
`endif
                    if (special) result_q <= special_val;
                end
                CALC: begin
                    prod <= step_val;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) result_q <= final_val;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors plus random traffic
// against a plain-arithmetic reference model.
module tb_muldiv_unit;

    localparam int DW = 32;

    logic          clk, rst_n, flush;
    logic [1:0]    alu_op;
    logic [6:0]    funct7;
    logic [2:0]    funct3;
    logic [DW-1:0] op_a, op_b, result;
    logic          in_valid, in_ready, m_sel, busy, out_valid, out_ready;

    typedef struct {
        logic [DW-1:0] res;
        int            edge_exp;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen = 0;
    bit   ready_next = 0;
    bit   stall = 0;
    bit   rnd_ready = 0;

    muldiv_unit #(.DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .alu_op    (alu_op),
        .funct7    (funct7),
        .funct3    (funct3),
        .op_a      (op_a),
        .op_b      (op_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .m_sel     (m_sel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = stall ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired: sim stuck, required completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout required=event", name);
    endtask

    // Reference: RV32M semantics from 64-bit integer arithmetic.
    function automatic void refModel(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b,
                                     output logic [DW-1:0] res, output bit special);
        longint sa, sbv, p;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sbv = longint'($signed(b));
        special = 0;
        res = '0;
        case (f3)
            3'd0: begin p = sa * sbv; res = p[31:0]; end
            3'd1: begin p = sa * sbv; res = p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); res = p[63:32]; end
            3'd3: begin pu = {32'b0, a} * {32'b0, b}; res = pu[63:32]; end
            default: begin
`ifdef MULDIV_DIV_EN
                if (b == 0) begin
                    special = 1;
                    res = (f3 == 3'd6 || f3 == 3'd7) ? a : 32'hFFFFFFFF;
                end else if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                    special = 1;
                    res = (f3 == 3'd6) ? 32'h0 : 32'h80000000;
                end else if (f3 == 3'd4) begin p = sa / sbv; res = p[31:0]; end
                else if (f3 == 3'd6) begin p = sa % sbv; res = p[31:0]; end
                else if (f3 == 3'd5) res = a / b;
                else res = a % b;
`else
                special = 1;
                res = '0;
`endif
            end
        endcase
    endfunction

    function automatic logic [DW-1:0] pickOperand();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFFFFFF;
            3: return 32'h80000000;
            4: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] f3, input logic [DW-1:0] a, input logic [DW-1:0] b);
        int n;
        exp_t e;
        logic [DW-1:0] r;
        bit sp;
        n = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            timeoutFail("in_ready_wait");
            return;
        end
        refModel(f3, a, b, r, sp);
        alu_op = 2'b10;
        funct7 = 7'b0000001;
        funct3 = f3;
        op_a = a;
        op_b = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        e.res = r;
        e.edge_exp = cyc + (sp ? 0 : DW);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        op_a = $urandom;
        op_b = $urandom;
        funct3 = 3'($urandom_range(0, 7));
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            timeoutFail("drain");
            sb.delete();
        end
    endtask

    // Monitor: pops the scoreboard on each out handshake.
    initial forever begin
        @(negedge clk);
        if (ready_next) begin
            ready_next = 0;
            checkOutput("in_ready_after_handshake", 32'(in_ready), 32'd1);
        end
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                timeoutFail("unexpected_out_valid");
            end else begin
                if (!seen) begin
                    seen = 1;
                    checkOutput("latency_edge", 32'(cyc), 32'(sb[0].edge_exp));
                end
                checkOutput("result", result, sb[0].res);
                checkOutput("in_ready_in_done", 32'(in_ready), 32'd0);
                checkOutput("busy_in_done", 32'(busy), 32'd1);
                if (out_ready) begin
                    void'(sb.pop_front());
                    seen = 0;
                    ready_next = 1;
                end
            end
        end
    end

    logic [2:0]    dir_f3[16];
    logic [DW-1:0] dir_a[16];
    logic [DW-1:0] dir_b[16];

    initial begin
        int n;
        dir_f3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7,
                   3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd0, 3'd1};
        dir_a  = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                   32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'd5, 32'h80000000, 32'hFFFFFFFF};
        dir_b  = '{32'd6, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7,
                   32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 32'd1};

        rst_n = 0; flush = 0; alu_op = 0; funct7 = 0; funct3 = 0;
        op_a = 0; op_b = 0; in_valid = 0;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1;

        alu_op = 2'b10; funct7 = 7'b0000001; #1;
        checkOutput("m_sel_rtype_mext", 32'(m_sel), 32'd1);
        funct7 = 7'b0000000; #1;
        checkOutput("m_sel_funct7_zero", 32'(m_sel), 32'd0);
        alu_op = 2'b00; funct7 = 7'b0000001; #1;
        checkOutput("m_sel_aluop_zero", 32'(m_sel), 32'd0);

        // Non-M requests must be ignored.
        @(negedge clk);
        alu_op = 2'b10; funct7 = 7'b0000000; funct3 = 3'd0; op_a = 7; op_b = 6; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("busy_non_m", 32'(busy), 32'd0);
        end
        in_valid = 0;

        for (int i = 0; i < 16; i++) begin
            applyStimulus(dir_f3[i], dir_a[i], dir_b[i]);
            waitDrain();
        end

        // Consumer stall: result held, in_ready low.
        stall = 1;
        applyStimulus(3'd0, 32'd7, 32'd6);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeoutFail("stall_out_valid_wait");
        repeat (5) @(negedge clk);
        stall = 0;
        waitDrain();

        // Flush in the middle of CALC discards the op.
        applyStimulus(3'd0, 32'($urandom_range(1, 1000)), 32'($urandom_range(1, 1000)));
        repeat (9) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        sb.delete();
        checkOutput("flush_busy", 32'(busy), 32'd0);
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of CALC.
        applyStimulus(3'd1, 32'($urandom), 32'($urandom));
        repeat (8) @(negedge clk);
        rst_n = 0;
        #1;
        sb.delete();
        checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("midreset_busy", 32'(busy), 32'd0);
        checkOutput("midreset_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1;
        repeat (40) @(negedge clk);

        rnd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), pickOperand(), pickOperand());
        end
        waitDrain();
        rnd_ready = 0;
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
